// File: rtl/heavy_hash_serializer_if.sv
// Bus between the hash core / FIFO pair and heavy_hash_serializer.
// Handshake: hash_din/nonce_din move when hash_valid & hash_ready are both high on a clk edge;
// hash_valid may not depend on hash_ready, and the payload holds while hash_valid is high.
interface heavy_hash_serializer_if #(
   parameter int BEAT_W    = 64,
   parameter int NUM_BEATS = 4,
   parameter int NONCE_W   = 32
);
   logic [BEAT_W*NUM_BEATS-1:0] hash_din;
   logic [NONCE_W-1:0]          nonce_din;
   logic                        hash_valid;
   logic                        hash_ready;
   logic                        hash_fifo_full;
   logic                        nonce_fifo_full;
   logic [BEAT_W-1:0]           hash_dout;
   logic                        hash_we;
   logic [NONCE_W-1:0]          nonce_dout;
   logic                        nonce_we;
   logic                        busy;
   logic [31:0]                 hashes_sent;
   logic [0:0]                  dbg_state;

   modport master (
      input  hash_din, nonce_din, hash_valid, hash_fifo_full, nonce_fifo_full,
      output hash_ready, hash_dout, hash_we, nonce_dout, nonce_we, busy, hashes_sent, dbg_state
   );

   modport slave (
      output hash_din, nonce_din, hash_valid, hash_fifo_full, nonce_fifo_full,
      input  hash_ready, hash_dout, hash_we, nonce_dout, nonce_we, busy, hashes_sent, dbg_state
   );
endinterface

// File: rtl/heavy_hash_serializer.sv
// Splits a 256-bit heavy-hash into 64-bit beats (MSW first) for the hashout FIFO, nonce on the last beat.
// Optional macro HASH_SER_DBUF_EN adds a one-entry holding slot so hashes stream without an IDLE bubble.
module heavy_hash_serializer #(
   parameter int BEAT_W    = 64,
   parameter int NUM_BEATS = 4,
   parameter int NONCE_W   = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stop,
   heavy_hash_serializer_if.master  bus
);
   localparam int HASH_W = BEAT_W * NUM_BEATS;
   localparam int CNT_W  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   logic [0:0]         r_state;
   logic [CNT_W-1:0]   r_beat_cnt;
   logic [HASH_W-1:0]  r_shift;
   logic [NONCE_W-1:0] r_nonce;
   logic [31:0]        r_hashes_sent;

   logic w_send;
   logic w_last;
   logic w_wr;
   logic w_done;
   logic w_ready;
   logic w_accept;

   assign w_send = (r_state == ST_SEND);
   assign w_last = (r_beat_cnt == CNT_W'(NUM_BEATS - 1));
   // The last beat waits for both FIFOs so hashout and nonce never drift apart.
   assign w_wr   = w_send & ~stop & ~bus.hash_fifo_full & (~w_last | ~bus.nonce_fifo_full);
   assign w_done = w_wr & w_last;

`ifdef HASH_SER_DBUF_EN
   logic               r_slot_full;
   logic [HASH_W-1:0]  r_slot_hash;
   logic [NONCE_W-1:0] r_slot_nonce;

   assign w_ready = ~rst & ~stop & (~w_send | ~r_slot_full);
`else
   assign w_ready = ~rst & ~stop & ~w_send;
`endif

   assign w_accept = bus.hash_valid & w_ready;

   always_ff @(posedge clk) begin
      if (rst || stop) begin
         r_state       <= ST_IDLE;
         r_beat_cnt    <= '0;
         r_shift       <= '0;
         r_nonce       <= '0;
         r_hashes_sent <= '0;
      end else begin
         if (w_wr) begin
            r_shift    <= r_shift << BEAT_W;
            r_beat_cnt <= r_beat_cnt + 1'b1;
         end
         if (w_done) begin
            r_hashes_sent <= r_hashes_sent + 32'd1;
            r_beat_cnt    <= '0;
            r_state       <= ST_IDLE;
         end
`ifdef HASH_SER_DBUF_EN
         if (w_done && r_slot_full) begin
            r_shift    <= r_slot_hash;
            r_nonce    <= r_slot_nonce;
            r_beat_cnt <= '0;
            r_state    <= ST_SEND;
         end
         // An accept coinciding with the final write has an empty slot, so it goes straight to shift.
         if (w_accept && (!w_send || w_done)) begin
            r_shift    <= bus.hash_din;
            r_nonce    <= bus.nonce_din;
            r_beat_cnt <= '0;
            r_state    <= ST_SEND;
         end
`else
         if (w_accept) begin
            r_shift    <= bus.hash_din;
            r_nonce    <= bus.nonce_din;
            r_beat_cnt <= '0;
            r_state    <= ST_SEND;
         end
`endif
      end
   end

`ifdef HASH_SER_DBUF_EN
   always_ff @(posedge clk) begin
      if (rst || stop) begin
         r_slot_full  <= 1'b0;
         r_slot_hash  <= '0;
         r_slot_nonce <= '0;
      end else begin
         if (w_done && r_slot_full) begin
            r_slot_full <= 1'b0;
         end
         if (w_accept && w_send && !w_done) begin
            r_slot_full  <= 1'b1;
            r_slot_hash  <= bus.hash_din;
            r_slot_nonce <= bus.nonce_din;
         end
      end
   end
`endif

   assign bus.hash_ready  = w_ready;
   assign bus.hash_dout   = r_shift[HASH_W-1 -: BEAT_W];
   assign bus.hash_we     = w_wr;
   assign bus.nonce_dout  = r_nonce;
   assign bus.nonce_we    = w_done;
   assign bus.busy        = w_send;
   assign bus.hashes_sent = r_hashes_sent;
   assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_heavy_hash_serializer.sv
// Directed bench for heavy_hash_serializer: driver tasks push expected beats/nonces,
// a negedge monitor pops and compares whenever the serializer writes a FIFO.
module tb_heavy_hash_serializer;
   logic clk;
   logic rst;
   logic stop;

   heavy_hash_serializer_if bus ();

   heavy_hash_serializer dut (
      .clk  (clk),
      .rst  (rst),
      .stop (stop),
      .bus  (bus.master)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [63:0] exp_beat_q[$];
   logic [31:0] exp_nonce_q[$];

   int mon_beat       = 0;
   bit meas_arm       = 0;
   int first_acc_cyc  = 0;
   int last_nonce_cyc = 0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic send_hash(input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3,
                            input logic [31:0] n);
      int k;
      bus.hash_din   = {b0, b1, b2, b3};
      bus.nonce_din  = n;
      bus.hash_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!bus.hash_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) chk("accept_timeout", 64'(k), 64'd0);
      exp_beat_q.push_back(b0);
      exp_beat_q.push_back(b1);
      exp_beat_q.push_back(b2);
      exp_beat_q.push_back(b3);
      exp_nonce_q.push_back(n);
      @(posedge clk);
      #1;
      bus.hash_valid = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      @(negedge clk);
      while ((exp_beat_q.size() != 0 || bus.busy) && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (k >= 300) chk("drain_timeout", 64'(k), 64'd0);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (stop) mon_beat = 0;
         if (meas_arm && bus.hash_valid && bus.hash_ready) begin
            first_acc_cyc = cyc;
            meas_arm      = 0;
         end
         if (bus.hash_we) begin
            if (exp_beat_q.size() == 0) chk("beat_unexpected", 64'd1, 64'd0);
            else chk("beat_data", bus.hash_dout, exp_beat_q.pop_front());
            chk("nonce_we_align", 64'(bus.nonce_we), 64'(mon_beat == 3));
            if (bus.nonce_we) begin
               if (exp_nonce_q.size() == 0) chk("nonce_unexpected", 64'd1, 64'd0);
               else chk("nonce_data", 64'(bus.nonce_dout), 64'(exp_nonce_q.pop_front()));
               last_nonce_cyc = cyc;
            end
            mon_beat = (mon_beat + 1) % 4;
         end else if (bus.nonce_we) begin
            chk("nonce_without_hash", 64'd1, 64'd0);
         end
      end
   end

   initial begin
      int exp_cycles;
      rst                 = 1'b1;
      stop                = 1'b0;
      bus.hash_valid      = 1'b0;
      bus.hash_din        = '0;
      bus.nonce_din       = '0;
      bus.hash_fifo_full  = 1'b0;
      bus.nonce_fifo_full = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("ready_in_rst", 64'(bus.hash_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 64'(bus.hash_ready), 64'd1);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_we", 64'({bus.hash_we, bus.nonce_we}), 64'd0);
      chk("rst_dout", bus.hash_dout, 64'd0);
      chk("rst_sent", 64'(bus.hashes_sent), 64'd0);

      // 1: single hash, four consecutive writes
      @(posedge clk); #1;
      send_hash(64'h0001_0002_0003_0004, 64'h0005_0006_0007_0008,
                64'h0009_000A_000B_000C, 64'h000D_000E_000F_0010, 32'hA5A5A5A5);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t1_consecutive_we", 64'(bus.hash_we), 64'd1);
         chk("t1_busy", 64'(bus.busy), 64'd1);
         if (i < 3) @(posedge clk);
      end
      drain();
      chk("t1_sent", 64'(bus.hashes_sent), 64'd1);

      // 2: hashout FIFO full during beat 1
      @(posedge clk); #1;
      send_hash(64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
                64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004, 32'h0000_0002);
      @(posedge clk); #1;
      bus.hash_fifo_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t2_stall_we", 64'(bus.hash_we), 64'd0);
         chk("t2_stall_hold", bus.hash_dout, 64'h2222_0000_0000_0002);
      end
      @(posedge clk); #1;
      bus.hash_fifo_full = 1'b0;
      drain();
      chk("t2_sent", 64'(bus.hashes_sent), 64'd2);

      // 3: nonce FIFO full on beat 3
      @(posedge clk); #1;
      send_hash(64'hAAAA_BBBB_CCCC_DDDD, 64'h0123_4567_89AB_CDEF,
                64'hFEDC_BA98_7654_3210, 64'h5555_6666_7777_8888, 32'h1234_5678);
      bus.nonce_fifo_full = 1'b1;
      repeat (3) @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_stall_we", 64'({bus.hash_we, bus.nonce_we}), 64'd0);
      end
      @(posedge clk); #1;
      bus.nonce_fifo_full = 1'b0;
      @(negedge clk);
      chk("t3_both_we", 64'({bus.hash_we, bus.nonce_we}), 64'd3);
      drain();
      chk("t3_sent", 64'(bus.hashes_sent), 64'd3);

      // 4: stop after beat 2
      @(posedge clk); #1;
      send_hash(64'hDEAD_0000_0000_0000, 64'hDEAD_0000_0000_0001,
                64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0003, 32'hDEAD_BEEF);
      repeat (3) @(posedge clk);
      #1 stop = 1'b1;
      @(negedge clk);
      chk("t4_stop_we", 64'({bus.hash_we, bus.nonce_we}), 64'd0);
      chk("t4_stop_ready", 64'(bus.hash_ready), 64'd0);
      @(posedge clk);
      #1 stop = 1'b0;
      exp_beat_q.delete();
      exp_nonce_q.delete();
      @(negedge clk);
      chk("t4_busy", 64'(bus.busy), 64'd0);
      chk("t4_sent", 64'(bus.hashes_sent), 64'd0);
      chk("t4_ready", 64'(bus.hash_ready), 64'd1);
      repeat (3) @(negedge clk);
      chk("t4_no_strobe", 64'({bus.hash_we, bus.nonce_we}), 64'd0);

      // 5: ten hashes back to back
      @(posedge clk); #1;
      meas_arm = 1;
      for (int h = 0; h < 10; h++) begin
         send_hash({32'h5000_0000, 32'(h)}, {32'h5100_0000, 32'(h)},
                   {32'h5200_0000, 32'(h)}, {32'h5300_0000, 32'(h)}, 32'hC000_0000 + 32'(h));
      end
      drain();
      chk("t5_sent", 64'(bus.hashes_sent), 64'd10);
`ifdef HASH_SER_DBUF_EN
      exp_cycles = 41;
`else
      exp_cycles = 50;
`endif
      chk("t5_cycles", 64'(last_nonce_cyc - first_acc_cyc + 1), 64'(exp_cycles));

      // 6: counter wrap
      @(posedge clk); #1;
      force dut.r_hashes_sent = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.r_hashes_sent;
      chk("t6_preload", 64'(bus.hashes_sent), 64'hFFFF_FFFF);
      @(posedge clk); #1;
      send_hash(64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
                64'h0000_FFFF_0000_FFFF, 64'hFFFF_0000_FFFF_0000, 32'h8000_0001);
      drain();
      chk("t6_wrap", 64'(bus.hashes_sent), 64'd0);

      chk("end_beat_q_empty", 64'(exp_beat_q.size()), 64'd0);
      chk("end_nonce_q_empty", 64'(exp_nonce_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
